// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage.
package imem_load_ctrl_pkg;

   localparam int unsigned IMEM_ADDR_W    = 16;
   localparam logic [7:0]  START_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_DONE
   } load_state_t;

   // States in which the loader waits on the byte stream and the idle watchdog runs.
   function automatic logic is_timed_state(input load_state_t s);
      return s inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
   endfunction

endpackage

// File: rtl/imem_load_ctrl_timeout.sv
// imem_load_timeout: idle-cycle watchdog; counts enabled cycles since the last clear
// and flags expiry once LIMIT is reached (count saturates there).
module imem_load_timeout #(
   parameter int unsigned LIMIT = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != CW'(LIMIT))) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && (count == CW'(LIMIT));

endmodule

// File: rtl/imem_load_ctrl.sv
// Byte-stream program loader: frames (start, 16-bit count, LE words) into imem writes.
// Optional trailing XOR checksum byte when IMEM_LOAD_CSUM_EN is defined.
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W         = IMEM_ADDR_W,
   parameter logic [7:0]  START_BYTE     = START_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_write_en,
   output logic [ADDR_W-1:0] imem_write_addr,
   output logic [31:0]       imem_write_data,
   output logic              core_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W-1:0] words_loaded
);

   load_state_t       state;
   logic [15:0]       count;
   logic [1:0]        byte_idx;
   logic [23:0]       word_buf;
   logic [ADDR_W-1:0] words_next;
   logic              accept;
   logic              timed;
   logic              expired;
`ifdef IMEM_LOAD_CSUM_EN
   logic [7:0]        csum;
`endif

   assign accept     = rx_valid && rx_ready;
   assign timed      = is_timed_state(state);
   assign words_next = words_loaded + ADDR_W'(1);

   imem_load_timeout #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept || !timed),
      .enable (timed),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         count           <= '0;
         byte_idx        <= '0;
         word_buf        <= '0;
         rx_ready        <= 1'b1;
         imem_write_en   <= 1'b0;
         imem_write_addr <= '0;
         imem_write_data <= '0;
         core_hold       <= 1'b0;
         load_done       <= 1'b0;
         load_error      <= 1'b0;
         words_loaded    <= '0;
`ifdef IMEM_LOAD_CSUM_EN
         csum            <= '0;
`endif
      end else begin
         imem_write_en <= 1'b0;
         load_done     <= 1'b0;
         // Expiry only acts when no byte arrives the same cycle; an accept restarts the count.
         if (expired && !accept) begin
            load_error <= 1'b1;
            core_hold  <= 1'b0;
            rx_ready   <= 1'b1;
            state      <= ST_IDLE;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (accept && (rx_data == START_BYTE)) begin
                     core_hold    <= 1'b1;
                     load_error   <= 1'b0;
                     words_loaded <= '0;
`ifdef IMEM_LOAD_CSUM_EN
                     csum         <= '0;
`endif
                     state        <= ST_LEN0;
                  end
               end
               ST_LEN0: begin
                  if (accept) begin
                     count[7:0] <= rx_data;
                     state      <= ST_LEN1;
                  end
               end
               ST_LEN1: begin
                  if (accept) begin
                     count[15:8]     <= rx_data;
                     byte_idx        <= '0;
                     imem_write_addr <= '0;
                     if ({rx_data, count[7:0]} == 16'd0) begin
`ifdef IMEM_LOAD_CSUM_EN
                        state     <= ST_CSUM;
`else
                        load_done <= 1'b1;
                        rx_ready  <= 1'b0;
                        state     <= ST_DONE;
`endif
                     end else begin
                        state <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (accept) begin
`ifdef IMEM_LOAD_CSUM_EN
                     csum <= csum ^ rx_data;
`endif
                     byte_idx <= byte_idx + 2'd1;
                     unique case (byte_idx)
                        2'd0: word_buf[7:0]   <= rx_data;
                        2'd1: word_buf[15:8]  <= rx_data;
                        2'd2: word_buf[23:16] <= rx_data;
                        default: begin
                           imem_write_data <= {rx_data, word_buf};
                           imem_write_addr <= words_loaded;
                           imem_write_en   <= 1'b1;
                           rx_ready        <= 1'b0;
                           state           <= ST_WRITE;
                        end
                     endcase
                  end
               end
               ST_WRITE: begin
                  words_loaded <= words_next;
                  byte_idx     <= '0;
                  if (words_next == ADDR_W'(count)) begin
`ifdef IMEM_LOAD_CSUM_EN
                     rx_ready  <= 1'b1;
                     state     <= ST_CSUM;
`else
                     load_done <= 1'b1;
                     state     <= ST_DONE;
`endif
                  end else begin
                     rx_ready <= 1'b1;
                     state    <= ST_DATA;
                  end
               end
               ST_CSUM: begin
`ifdef IMEM_LOAD_CSUM_EN
                  if (accept) begin
                     if (rx_data == csum) begin
                        load_done <= 1'b1;
                        rx_ready  <= 1'b0;
                        state     <= ST_DONE;
                     end else begin
                        load_error <= 1'b1;
                        core_hold  <= 1'b0;
                        state      <= ST_IDLE;
                     end
                  end
`else
                  state <= ST_IDLE;
`endif
               end
               ST_DONE: begin
                  core_hold <= 1'b0;
                  rx_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
               default: begin
                  rx_ready <= 1'b1;
                  state    <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl against a frame-level reference model.
module tb_imem_load_ctrl;

   localparam int unsigned AW  = 16;
   localparam int unsigned TMO = 16;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          imem_write_en;
   logic [AW-1:0] imem_write_addr;
   logic [31:0]   imem_write_data;
   logic          core_hold;
   logic          load_done;
   logic          load_error;
   logic [AW-1:0] words_loaded;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   wr_t         obs[$];
   int unsigned done_seen = 0;

   wr_t         exp_q[$];
   logic        exp_ok;
   int unsigned exp_cnt;

   always #5 clk = ~clk;

   imem_load_ctrl #(
      .ADDR_W        (AW),
      .START_BYTE    (8'hA5),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .imem_write_en  (imem_write_en),
      .imem_write_addr(imem_write_addr),
      .imem_write_data(imem_write_data),
      .core_hold      (core_hold),
      .load_done      (load_done),
      .load_error     (load_error),
      .words_loaded   (words_loaded)
   );

   always @(negedge clk) begin
      if (imem_write_en) obs.push_back(wr_t'({imem_write_addr, imem_write_data}));
      if (load_done) done_seen++;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Frame-level model: word i lands at address i, built little-endian from bytes 3+4i..6+4i.
   function automatic void model(input bq_t f);
      int unsigned b;
      logic [31:0] w;
      logic [7:0]  x;
      exp_q.delete();
      x       = 8'h00;
      exp_cnt = int'(f[1]) + 256 * int'(f[2]);
      for (int unsigned i = 0; i < exp_cnt; i++) begin
         b = 3 + 4 * i;
         w = 32'(f[b]) + (32'(f[b+1]) << 8) + (32'(f[b+2]) << 16) + (32'(f[b+3]) << 24);
         x = x ^ f[b] ^ f[b+1] ^ f[b+2] ^ f[b+3];
         exp_q.push_back(wr_t'({AW'(i), w}));
      end
`ifdef IMEM_LOAD_CSUM_EN
      exp_ok = (f[3 + 4 * exp_cnt] == x);
`else
      exp_ok = 1'b1;
`endif
   endfunction

   function automatic bq_t with_csum(input bq_t f);
      bq_t r;
      logic [7:0] x;
      r = f;
      x = 8'h00;
      for (int i = 3; i < f.size(); i++) x = x ^ f[i];
`ifdef IMEM_LOAD_CSUM_EN
      r.push_back(x);
`endif
      return r;
   endfunction

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int unsigned n;
      n = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= 64) begin
         n_err++;
         $display("FAIL rx_ready_wait: rx_ready=%b after %0d cycles, required 1", rx_ready, n);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic run_frame(input bq_t f, input string name);
      int unsigned ob, db, n;
      model(f);
      ob = obs.size();
      db = done_seen;
      foreach (f[i]) begin
         if (i > 0 && ($urandom % 4) == 0) idle($urandom_range(1, 4));
         send_byte(f[i]);
      end
      n = 0;
      while (!load_done && !load_error && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= 50) begin
         n_err++;
         $display("FAIL %s end_wait: no load_done/load_error within 50 cycles", name);
      end
      if (load_done) begin
         n_cmp++;
         if (core_hold !== 1'b1) begin
            n_err++;
            $display("FAIL %s hold_at_done: got %b required 1", name, core_hold);
         end
      end
      idle(3);
      n_cmp++;
      if (obs.size() - ob != exp_q.size()) begin
         n_err++;
         $display("FAIL %s write_count: got %0d required %0d", name, obs.size() - ob, exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            n_cmp++;
            if (obs[ob + i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL %s write[%0d]: got %h/%h required %h/%h", name, i,
                        obs[ob + i].addr, obs[ob + i].data, exp_q[i].addr, exp_q[i].data);
            end
         end
      end
      n_cmp++;
      if (done_seen - db != (exp_ok ? 1 : 0)) begin
         n_err++;
         $display("FAIL %s done_pulses: got %0d required %0d", name, done_seen - db, exp_ok ? 1 : 0);
      end
      n_cmp++;
      if (load_error !== !exp_ok) begin
         n_err++;
         $display("FAIL %s load_error: got %b required %b", name, load_error, !exp_ok);
      end
      n_cmp++;
      if (words_loaded !== AW'(exp_cnt)) begin
         n_err++;
         $display("FAIL %s words_loaded: got %0d required %0d", name, words_loaded, exp_cnt);
      end
      n_cmp++;
      if (core_hold !== 1'b0 || rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s idle_after: hold=%b ready=%b required 0/1", name, core_hold, rx_ready);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      n_cmp++;
      if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset rx_ready: got %b required 1", rx_ready); end
      n_cmp++;
      if (imem_write_en !== 1'b0) begin n_err++; $display("FAIL reset write_en: got %b required 0", imem_write_en); end
      n_cmp++;
      if (imem_write_addr !== '0 || imem_write_data !== '0) begin
         n_err++;
         $display("FAIL reset addr_data: got %h/%h required 0/0", imem_write_addr, imem_write_data);
      end
      n_cmp++;
      if (core_hold !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin
         n_err++;
         $display("FAIL reset flags: hold=%b done=%b err=%b required 0/0/0", core_hold, load_done, load_error);
      end
      n_cmp++;
      if (words_loaded !== '0) begin n_err++; $display("FAIL reset words_loaded: got %0d required 0", words_loaded); end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_basic_frame();
      bq_t f;
      int unsigned ob;
      f  = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      f  = with_csum(f);
      ob = obs.size();
      run_frame(f, "basic");
      n_cmp++;
      if (obs.size() < ob + 2 || obs[ob].data !== 32'h12345678 || obs[ob + 1].data !== 32'hDEADBEEF
          || obs[ob].addr !== '0 || obs[ob + 1].addr !== AW'(1)) begin
         n_err++;
         $display("FAIL basic literal_words: got %0d writes, required 0:12345678 1:DEADBEEF", obs.size() - ob);
      end
   endtask

   task automatic test_garbage();
      bq_t f;
      int unsigned ob, db;
      ob = obs.size();
      db = done_seen;
      send_byte(8'h00);
      send_byte(8'hFF);
      idle(2);
      n_cmp++;
      if (core_hold !== 1'b0 || obs.size() != ob || done_seen != db || rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL garbage ignored: hold=%b writes=%0d done=%0d ready=%b required 0/0/0/1",
                  core_hold, obs.size() - ob, done_seen - db, rx_ready);
      end
      f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(with_csum(f), "after_garbage");
   endtask

   task automatic test_zero_count();
      int unsigned ob, db;
      ob = obs.size();
      db = done_seen;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
`ifdef IMEM_LOAD_CSUM_EN
      send_byte(8'h00);
`endif
      n_cmp++;
      if (load_done !== 1'b1 || core_hold !== 1'b1) begin
         n_err++;
         $display("FAIL zero_count done_timing: done=%b hold=%b required 1/1", load_done, core_hold);
      end
      idle(3);
      n_cmp++;
      if (obs.size() != ob || words_loaded !== '0 || done_seen - db != 1 || core_hold !== 1'b0) begin
         n_err++;
         $display("FAIL zero_count result: writes=%0d words=%0d done=%0d hold=%b required 0/0/1/0",
                  obs.size() - ob, words_loaded, done_seen - db, core_hold);
      end
   endtask

   task automatic test_timeout();
      int unsigned ob, db, n;
      ob = obs.size();
      db = done_seen;
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      idle(10);
      n_cmp++;
      if (core_hold !== 1'b1 || load_error !== 1'b0) begin
         n_err++;
         $display("FAIL timeout early: hold=%b err=%b required 1/0", core_hold, load_error);
      end
      n = 10;
      while (!load_error && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n < TMO - 1 || n > TMO + 3) begin
         n_err++;
         $display("FAIL timeout delay: got %0d stall cycles required %0d..%0d", n, TMO - 1, TMO + 3);
      end
      n_cmp++;
      if (load_error !== 1'b1 || core_hold !== 1'b0 || rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL timeout flags: err=%b hold=%b ready=%b required 1/0/1", load_error, core_hold, rx_ready);
      end
      n_cmp++;
      if (obs.size() != ob || done_seen != db) begin
         n_err++;
         $display("FAIL timeout side_effects: writes=%0d done=%0d required 0/0", obs.size() - ob, done_seen - db);
      end
      idle(5);
      n_cmp++;
      if (load_error !== 1'b1) begin n_err++; $display("FAIL timeout sticky: got %b required 1", load_error); end
      send_byte(8'hA5);
      n_cmp++;
      if (load_error !== 1'b0 || core_hold !== 1'b1) begin
         n_err++;
         $display("FAIL timeout clear_on_start: err=%b hold=%b required 0/1", load_error, core_hold);
      end
      send_byte(8'h00);
      send_byte(8'h00);
`ifdef IMEM_LOAD_CSUM_EN
      send_byte(8'h00);
`endif
      idle(3);
      n_cmp++;
      if (done_seen - db != 1 || load_error !== 1'b0) begin
         n_err++;
         $display("FAIL timeout recovery: done=%0d err=%b required 1/0", done_seen - db, load_error);
      end
   endtask

   task automatic test_reset_mid_frame();
      bq_t f;
      int unsigned ob;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (core_hold !== 1'b0 || rx_ready !== 1'b1 || imem_write_en !== 1'b0 || load_done !== 1'b0
          || load_error !== 1'b0 || words_loaded !== '0 || imem_write_addr !== '0) begin
         n_err++;
         $display("FAIL reset_mid outputs: hold=%b ready=%b we=%b done=%b err=%b words=%0d addr=%0d required 0/1/0/0/0/0/0",
                  core_hold, rx_ready, imem_write_en, load_done, load_error, words_loaded, imem_write_addr);
      end
      rst = 1'b0;
      idle(1);
      ob = obs.size();
      f  = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hC0, 8'hAD, 8'h0B};
      run_frame(with_csum(f), "after_reset");
      n_cmp++;
      if (obs.size() < ob + 1 || obs[ob].addr !== '0 || obs[ob].data !== 32'h0BADC0DE) begin
         n_err++;
         $display("FAIL after_reset first_write: got %0d writes, required addr 0 data 0BADC0DE", obs.size() - ob);
      end
   endtask

   task automatic test_random_frames();
      bq_t f;
      int unsigned cnt;
      for (int k = 0; k < 6; k++) begin
         cnt = $urandom_range(1, 5);
         f   = '{8'hA5};
         f.push_back(8'(cnt));
         f.push_back(8'(cnt >> 8));
         for (int unsigned i = 0; i < 4 * cnt; i++) f.push_back(8'($urandom));
         f = with_csum(f);
`ifdef IMEM_LOAD_CSUM_EN
         if (($urandom % 3) == 0) f[f.size() - 1] = f[f.size() - 1] ^ 8'h5A;
`endif
         run_frame(f, "random");
      end
   endtask

`ifdef IMEM_LOAD_CSUM_EN
   task automatic test_checksum();
      bq_t f;
      int unsigned ob;
      ob = obs.size();
      f  = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      run_frame(f, "csum_good");
      n_cmp++;
      if (obs.size() < ob + 1 || obs[ob].data !== 32'h04030201 || load_error !== 1'b0) begin
         n_err++;
         $display("FAIL csum_good word: err=%b required write 04030201 and err 0", load_error);
      end
      ob = obs.size();
      f  = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run_frame(f, "csum_bad");
      n_cmp++;
      if (obs.size() < ob + 1 || obs[ob].addr !== '0 || obs[ob].data !== 32'h04030201 || load_error !== 1'b1) begin
         n_err++;
         $display("FAIL csum_bad word_kept: err=%b required write 0:04030201 and err 1", load_error);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_garbage();
      test_zero_count();
      test_timeout();
      test_reset_mid_frame();
      test_random_frames();
`ifdef IMEM_LOAD_CSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
